stream_classifier: RTL

STREAM_CLASSIFIER -- requirements
Module: stream_classifier

---
 rtl/stream_classifier_if.sv | 10 +
 rtl/stream_classifier.sv | 130 +++++++++++++
 2 files changed

// File: rtl/stream_classifier_if.sv
// Byte-stream handshake between a frame source and the stream classifier.
interface stream_classifier_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;

  modport master (output data_in, output data_valid, output data_last, input data_ready);
  modport slave  (input data_in, input data_valid, input data_last, output data_ready);
endinterface

// File: rtl/stream_classifier.sv
// Frame classifier: checks a 4-byte signature and the total frame length,
// then pulses action_trigger on a match or frame_error on a malformed frame.
//
//   state | meaning
//   IDLE  | waiting for the first byte of a frame
//   HDR   | signature bytes 1..3 being compared
//   BODY  | header matched, counting payload until last
//   FLUSH | frame rejected, dropping bytes until last
//   FIRE  | one-cycle match pulse, input stalled
module stream_classifier #(
  parameter logic [31:0] SIG     = 32'hCAFEF00D,
  parameter int          MIN_LEN = 8,
  parameter int          MAX_LEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_classifier_if.slave   s,
  output logic                 action_trigger,
  output logic                 frame_error,
  output logic [15:0]          match_count
);

  typedef enum logic [2:0] {IDLE, HDR, BODY, FLUSH, FIRE} state_t;

  localparam logic [7:0] MIN_L = 8'(MIN_LEN);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] hdr_exp;
  logic       accept;
  logic       len_ok;
  logic       err_d;

  assign s.data_ready = (state_q != FIRE);
  assign accept       = s.data_valid && s.data_ready;

  always_comb begin
    len_d = len_q;
    if (accept) begin
      if (state_q == IDLE)
        len_d = 8'd1;
      else if (len_q != 8'hFF)
        len_d = len_q + 8'd1;
    end
  end

  // len_q holds how many header bytes were already taken, i.e. the next index
  always_comb begin
    case (len_q[1:0])
      2'd1:    hdr_exp = SIG[23:16];
      2'd2:    hdr_exp = SIG[15:8];
      default: hdr_exp = SIG[7:0];
    endcase
  end

  // A saturated counter means the real length is unknown and too long
  assign len_ok = (len_d != 8'hFF) && (len_d >= MIN_L) && (len_d <= MAX_L);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (s.data_in == SIG[31:24]) begin
            if (s.data_last) err_d = 1'b1;
            else             state_d = HDR;
          end else if (!s.data_last) begin
            state_d = FLUSH;
          end
        end
      end
      HDR: begin
        if (accept) begin
          if (s.data_in == hdr_exp) begin
            if (len_q == 8'd3) begin
              if (!s.data_last) begin
                state_d = BODY;
              end else if (len_ok) begin
                state_d = FIRE;
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end else if (s.data_last) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            state_d = s.data_last ? IDLE : FLUSH;
          end
        end
      end
      BODY: begin
        if (accept && s.data_last) begin
          if (len_ok) begin
            state_d = FIRE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (accept && s.data_last) state_d = IDLE;
      end
      FIRE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      len_q          <= 8'd0;
      action_trigger <= 1'b0;
      frame_error    <= 1'b0;
      match_count    <= 16'd0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      action_trigger <= (state_d == FIRE);
      frame_error    <= err_d;
      if (state_d == FIRE && match_count != 16'hFFFF)
        match_count <= match_count + 16'd1;
    end
  end

endmodule
